// File: rtl/serial_adder_pkg.sv
// Package: serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_t     : FSM state encoding (IDLE, SHIFT)
//   - DEF_WIDTH   : default operand width
//   - CNT_W       : bit-counter width for DEF_WIDTH
//   - cnt_width() : bit-counter width for an arbitrary operand width
package serial_adder_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // The counter runs 0..w-1, so $clog2(w) bits suffice for w >= 2.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Module: fa_cell
//   Combinational 1-bit full adder.
//   Ports:
//     a, b   in  operand bits
//     c      in  carry in
//     sum    out sum bit
//     carry  out carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Module: serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an accepted start and
//   fed LSB-first through a single full-adder cell, one bit per clock, with the
//   carry held in a flip-flop. The result is assembled in a shift register and
//   published together with the final carry and a one-cycle done pulse.
//   Optional feature macro: SERIAL_SUB_EN (adds the sub port for a-b).
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     start  in   request, sampled only in IDLE
//     a, b   in   WIDTH-bit operands, sampled on the accepting edge
//     sub    in   subtract select (SERIAL_SUB_EN only)
//     busy   out  operation in progress
//     done   out  one-cycle result-valid pulse
//     sum    out  WIDTH-bit result, held between completions
//     cout   out  carry out of the MSB (in subtract mode: 1 = no borrow)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 bits are kept: the final sum bit goes straight into 'sum'.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_q;
  logic             sub_in;
  logic             fa_s;
  logic             fa_c;

`ifdef SERIAL_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert B bits and seed the carry with 1.
  fa_cell u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0] ^ sub_q),
    .c     (carry),
    .sum   (fa_s),
    .carry (fa_c)
  );

  assign res_next = {fa_s, res_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            sub_q <= sub_in;
            carry <= sub_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= fa_c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = W'(x - y);
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  // Drives one accepted request and returns edges from accept to done (-1 on timeout).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        output int lat);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= W + 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
               busy, done, sum, cout);
    end
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(8'h5A, 8'h3C, 1'b0, lat);
    checks++;
    if (lat !== W) begin
      failures++;
      $display("FAIL add_latency: got %0d required %0d", lat, W);
    end
    checks++;
    if ({cout, sum} !== 9'h096) begin
      failures++;
      $display("FAIL add_5a_3c: sum=%h cout=%b required 96 0", sum, cout);
    end
    run_op(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== W || {cout, sum} !== 9'h100) begin
      failures++;
      $display("FAIL add_ff_01: lat=%0d sum=%h cout=%b required %0d 00 1", lat, sum, cout, W);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_midop: busy=%b required 1", busy);
    end
    lat = -1;
    for (int k = 4; k <= W + 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== W || {cout, sum} !== 9'h096) begin
      failures++;
      $display("FAIL busy_ignore: lat=%0d sum=%h cout=%b required %0d 96 0", lat, sum, cout, W);
    end
    // Request during the done cycle: accepted at the next edge, no idle gap.
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h96) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b sum=%h required 1 0 96", busy, done, sum);
    end
    lat = -1;
    for (int k = 1; k <= W + 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== W || {cout, sum} !== 9'h002) begin
      failures++;
      $display("FAIL b2b_result: lat=%0d sum=%h cout=%b required %0d 02 0", lat, sum, cout, W);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    int seen;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL midop_reset: busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
               busy, done, sum, cout);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0 || sum !== 8'h00) begin
      failures++;
      $display("FAIL midop_no_done: activity=%0d sum=%h required 0 00", seen, sum);
    end
    run_op(8'h5A, 8'h3C, 1'b0, lat);
    checks++;
    if (lat !== W || {cout, sum} !== 9'h096) begin
      failures++;
      $display("FAIL midop_next: lat=%0d sum=%h cout=%b required %0d 96 0", lat, sum, cout, W);
    end
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    int lat;
    run_op(8'h10, 8'h01, 1'b1, lat);
    checks++;
    if (lat !== W || {cout, sum} !== 9'h10F) begin
      failures++;
      $display("FAIL sub_10_01: lat=%0d sum=%h cout=%b required %0d 0f 1", lat, sum, cout, W);
    end
    run_op(8'h01, 8'h02, 1'b1, lat);
    checks++;
    if (lat !== W || {cout, sum} !== 9'h0FF) begin
      failures++;
      $display("FAIL sub_01_02: lat=%0d sum=%h cout=%b required %0d ff 0", lat, sum, cout, W);
    end
    @(negedge clk);
    a = 8'h40; b = 8'h15; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= W + 8; k++) begin
      @(negedge clk); sub = ~sub;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== W || {cout, sum} !== 9'h12B) begin
      failures++;
      $display("FAIL sub_toggle: lat=%0d sum=%h cout=%b required %0d 2b 1", lat, sum, cout, W);
    end
    sub = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rs;
    logic [W:0]   exp;
    logic [W:0]   held;
    int           lat;
    held = {cout, sum};
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      exp = model(ra, rb, rs);
      @(negedge clk);
      a = ra; b = rb; sub = rs; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      lat = -1;
      for (int k = 1; k <= W + 8; k++) begin
        @(posedge clk); #1;
        if (done) begin
          lat = k;
          break;
        end
        checks++;
        if ({cout, sum} !== held) begin
          failures++;
          $display("FAIL rand_stable op%0d: sum=%h cout=%b required %h %b",
                   n, sum, cout, held[W-1:0], held[W]);
        end
      end
      checks++;
      if (lat !== W || {cout, sum} !== exp) begin
        failures++;
        $display("FAIL rand_op%0d a=%h b=%h sub=%b: lat=%0d sum=%h cout=%b required %0d %h %b",
                 n, ra, rb, rs, lat, sum, cout, W, exp[W-1:0], exp[W]);
      end
      held = exp;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_midop();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
